// File: rtl/race_pkg.sv
// Shared state encoding and default geometry for the car-game draw controller.
package race_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BG_LEFT  = 3'd1,
        BG_ROAD  = 3'd2,
        BG_RIGHT = 3'd3,
        WAIT     = 3'd4,
        ERASE    = 3'd5,
        DRIVE    = 3'd6,
        CAR      = 3'd7
    } state_t;

    localparam int unsigned GRASS_W  = 40;
    localparam int unsigned ROAD_W   = 80;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned CAR_W    = 8;
    localparam int unsigned CAR_H    = 12;
    localparam int unsigned SCREEN_W = 160;

    // States that sweep a rectangular region one pixel per cycle.
    function automatic logic is_region(state_t s);
        return (s == BG_LEFT) || (s == BG_ROAD) || (s == BG_RIGHT) ||
               (s == ERASE) || (s == CAR);
    endfunction

endpackage

// File: rtl/race_draw_ctrl_if.sv
// Controller <-> pixel datapath bundle: counters in, strobes and row/region control out.
interface race_draw_ctrl_if;

    logic [7:0] xcounter;
    logic [7:0] ycounter;
    logic       draw_bg_black;
    logic       draw_bg_green_left;
    logic       draw_bg_green_right;
    logic       draw_car;
    logic       erase;
    logic       drive;
    logic       plot;
    logic       inc;
    logic       done;

    modport master (
        input  xcounter, ycounter,
        output draw_bg_black, draw_bg_green_left, draw_bg_green_right,
               draw_car, erase, drive, plot, inc, done
    );

    modport slave (
        output xcounter, ycounter,
        input  draw_bg_black, draw_bg_green_left, draw_bg_green_right,
               draw_car, erase, drive, plot, inc, done
    );

endinterface

// File: rtl/region_scan_cmp.sv
// End-of-row / end-of-region detection for a W x H raster scan.
module region_scan_cmp (
    input  logic [7:0] xcounter,
    input  logic [7:0] ycounter,
    input  logic [7:0] region_w,
    input  logic [7:0] region_h,
    input  logic       active,
    output logic       inc,
    output logic       done
);

    logic w_last_col;
    logic w_last_row;

    assign w_last_col = (xcounter == region_w - 8'd1);
    assign w_last_row = (ycounter == region_h - 8'd1);

    assign inc  = active && w_last_col && !w_last_row;
    assign done = active && w_last_col && w_last_row;

endmodule

// File: rtl/race_draw_ctrl.sv
// Draw sequencer: background sweep once, then per-frame erase / drive / redraw of the car.
module race_draw_ctrl #(
    parameter int unsigned GRASS_W  = race_pkg::GRASS_W,
    parameter int unsigned ROAD_W   = race_pkg::ROAD_W,
    parameter int unsigned SCREEN_H = race_pkg::SCREEN_H,
    parameter int unsigned CAR_W    = race_pkg::CAR_W,
    parameter int unsigned CAR_H    = race_pkg::CAR_H
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                frame_tick,
    race_draw_ctrl_if.master    dp,
    output logic [7:0]          frame_count
);

    import race_pkg::*;

    localparam logic [7:0] GRASS_W8  = 8'(GRASS_W);
    localparam logic [7:0] ROAD_W8   = 8'(ROAD_W);
    localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);
    localparam logic [7:0] CAR_W8    = 8'(CAR_W);
    localparam logic [7:0] CAR_H8    = 8'(CAR_H);

    state_t     r_state;
    state_t     w_next;
    logic       r_tick_pending;
    logic [7:0] r_frame_count;
    logic       r_black, r_green_left, r_green_right, r_car, r_erase, r_drive, r_plot;
    logic [7:0] w_region_w;
    logic [7:0] w_region_h;
    logic       w_active;
    logic       w_inc;
    logic       w_done;

    always_comb begin
        w_region_w = '0;
        w_region_h = '0;
        case (r_state)
            BG_LEFT, BG_RIGHT: begin w_region_w = GRASS_W8; w_region_h = SCREEN_H8; end
            BG_ROAD:           begin w_region_w = ROAD_W8;  w_region_h = SCREEN_H8; end
            ERASE, CAR:        begin w_region_w = CAR_W8;   w_region_h = CAR_H8;    end
            default:           begin w_region_w = '0;       w_region_h = '0;        end
        endcase
    end

    assign w_active = is_region(r_state);

    region_scan_cmp u_scan (
        .xcounter (dp.xcounter),
        .ycounter (dp.ycounter),
        .region_w (w_region_w),
        .region_h (w_region_h),
        .active   (w_active),
        .inc      (w_inc),
        .done     (w_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start) w_next = BG_LEFT;
            BG_LEFT:  if (w_done) w_next = BG_ROAD;
            BG_ROAD:  if (w_done) w_next = BG_RIGHT;
            BG_RIGHT: if (w_done) w_next = WAIT;
            WAIT:     if (frame_tick || r_tick_pending) w_next = ERASE;
            ERASE:    if (w_done) w_next = DRIVE;
            DRIVE:    w_next = CAR;
            CAR:      if (w_done) w_next = WAIT;
            default:  w_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_tick_pending <= 1'b0;
            r_frame_count  <= '0;
            r_black        <= 1'b0;
            r_green_left   <= 1'b0;
            r_green_right  <= 1'b0;
            r_car          <= 1'b0;
            r_erase        <= 1'b0;
            r_drive        <= 1'b0;
            r_plot         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT && w_next == ERASE)
                r_tick_pending <= 1'b0;
            else if (frame_tick && r_state != IDLE && r_state != WAIT)
                r_tick_pending <= 1'b1;
            if (r_state == CAR && w_done)
                r_frame_count <= r_frame_count + 8'd1;
            r_green_left  <= (w_next == BG_LEFT);
            r_black       <= (w_next == BG_ROAD);
            r_green_right <= (w_next == BG_RIGHT);
            r_erase       <= (w_next == ERASE);
            r_car         <= (w_next == CAR);
            r_drive       <= (w_next == DRIVE);
            r_plot        <= is_region(w_next);
        end
    end

    assign dp.draw_bg_black       = r_black;
    assign dp.draw_bg_green_left  = r_green_left;
    assign dp.draw_bg_green_right = r_green_right;
    assign dp.draw_car            = r_car;
    assign dp.erase               = r_erase;
    assign dp.drive               = r_drive;
    assign dp.plot                = r_plot;
    assign dp.inc                 = w_inc;
    assign dp.done                = w_done;
    assign frame_count            = r_frame_count;

endmodule

// File: doc/race_draw_ctrl.md
Name: race_draw_ctrl

Overview:
- Control FSM directly upstream of the pixel datapath in the car game.
- Sequences full-screen background draw (left grass, black road, right grass), then a per-frame erase/drive/draw of the car.
- Drives the datapath's region-select strobes and plot enable.
- Generates the datapath's row-advance (inc) and region-complete (done) from the datapath's pixel counters.

Parameters:
- GRASS_W, 40, width in pixels of each green verge; left verge at x 0..GRASS_W-1.
- ROAD_W, 80, width of the black road, starting at x=GRASS_W.
- SCREEN_H, 120, rows per background region.
- CAR_W, 8, car sprite width.
- CAR_H, 12, car sprite height.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  level; leaving IDLE requires start=1.
- frame_tick  in  1  one-cycle pulse per animation frame (~60 Hz).
- xcounter  in  8  datapath column counter within the current region.
- ycounter  in  8  datapath row counter within the current region.
- draw_bg_black  out  1  select black road fill.
- draw_bg_green_left  out  1  select left verge fill.
- draw_bg_green_right  out  1  select right verge fill.
- draw_car  out  1  select car sprite colour.
- erase  out  1  select car-footprint erase (black).
- drive  out  1  one-cycle pulse; datapath updates car position.
- plot  out  1  VGA write enable.
- inc  out  1  datapath: next row, clear column.
- done  out  1  datapath: region complete, clear both counters.
- frame_count  out  8  completed car frames, wraps 255->0.

Behaviour:
- States: IDLE, BG_LEFT, BG_ROAD, BG_RIGHT, WAIT, ERASE, DRIVE, CAR.
- Reset (reset=0 at an edge): state=IDLE, tick_pending=0, frame_count=0.
- All strobes, plot, inc and done are 0 in IDLE and WAIT, including directly after reset.
- Reset has priority over every other input, including mid-region. The bench drives the datapath counters to 0 alongside reset.
- Region geometry per state (W x H):
  - BG_LEFT and BG_RIGHT: GRASS_W x SCREEN_H.
  - BG_ROAD: ROAD_W x SCREEN_H.
  - ERASE and CAR: CAR_W x CAR_H.
- Strobes are Moore outputs, exactly one asserted per draw state:
  - BG_LEFT -> draw_bg_green_left; BG_ROAD -> draw_bg_black; BG_RIGHT -> draw_bg_green_right.
  - ERASE -> erase; CAR -> draw_car.
  - plot=1 in every draw state, every cycle.
- inc and done are combinational from state and counters; both are 0 outside draw states.
  - inc = (xcounter==W-1) && (ycounter!=H-1).
  - done = (xcounter==W-1) && (ycounter==H-1).
  - inc and done are never both 1.
- A region therefore lasts exactly W*H cycles: one pixel per cycle, no gaps.
- Transitions:
  - IDLE -> BG_LEFT when start=1.
  - On done: BG_LEFT -> BG_ROAD -> BG_RIGHT -> WAIT.
  - WAIT -> ERASE when frame_tick=1 or tick_pending=1.
  - On done: ERASE -> DRIVE.
  - DRIVE lasts 1 cycle: drive=1, plot=0, then -> CAR.
  - On done: CAR -> WAIT, frame_count increments the same edge.
- tick_pending:
  - Set by frame_tick in any state other than WAIT and IDLE.
  - Cleared on the WAIT->ERASE transition.
  - Multiple ticks while busy collapse to one extra frame.
  - A frame_tick in IDLE is dropped.
- start is ignored outside IDLE. Deasserting start mid-run has no effect.
- Counter values beyond the region bounds never advance state (no done); the datapath is required to stay in bounds.
- Widths: all comparisons are 8-bit unsigned; parameters must satisfy W,H <= 255.

Decomposition:
- Package race_pkg:
  - state enum/localparams: IDLE=0, BG_LEFT=1, BG_ROAD=2, BG_RIGHT=3, WAIT=4, ERASE=5, DRIVE=6, CAR=7 (3-bit encoding).
  - geometry defaults: GRASS_W, ROAD_W, SCREEN_H, CAR_W, CAR_H, SCREEN_W=160.
- Sub-module region_scan_cmp:
  - inputs: xcounter, ycounter, region W and H (muxed from state), active.
  - outputs: inc, done.
  - instantiated once.

Test Plan:
- Reset held 3 cycles while start=1 -> all outputs 0, frame_count=0. First cycle after release: state BG_LEFT, draw_bg_green_left=1, plot=1.
- Background sweep, bench model incrementing counters from inc/done:
  - BG_LEFT 4800 cycles, BG_ROAD 9600, BG_RIGHT 4800; 19200 plot cycles total.
  - done pulses exactly 3 times; inc pulses 119 times per region.
- In WAIT, pulse frame_tick -> next cycle ERASE.
  - erase for 96 cycles, then drive=1 with plot=0 for exactly 1 cycle.
  - draw_car for 96 cycles, then frame_count=1.
- Boundary at (x=39, y=118) in BG_LEFT -> inc=1, done=0.
  - At (39,119) -> done=1, inc=0; next cycle draw_bg_black=1.
- Three frame_ticks during CAR -> exactly one further ERASE/DRIVE/CAR pass without waiting, then WAIT until the next tick.
- 256 frames -> frame_count wraps to 0. Reset asserted mid-ERASE -> IDLE next cycle, tick_pending cleared.
